// File: rtl/aes_pkg.sv
// Shared AES definitions: byte/word types and the FIPS-197 forward S-box.
// Also used by key expansion (SubWord), so keep it free of round-specific logic.
package aes_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

  localparam byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic byte_t sub_byte(byte_t x);
    return SBOX[x];
  endfunction

endpackage

// File: rtl/sbox_byte.sv
// Single-byte forward S-box: pure combinational table lookup.
module sbox_byte
  import aes_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  // An unknown index yields an unknown result for this byte alone.
  assign byte_o = sub_byte(byte_i);

endmodule

// File: rtl/aes_s_box.sv
// SubBytes for one 32-bit row: four independent byte lanes, with a
// zero-latency combinational result and a one-cycle registered copy.
module aes_s_box
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] row_in,
  output logic [31:0] row_out,
  output logic [31:0] row_out_q
);

  word_t row_d;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    sbox_byte u_sbox (
      .byte_i (row_in[8*i +: 8]),
      .byte_o (row_d[8*i +: 8])
    );
  end

  assign row_out = row_d;

  // NOTE: only the output flop is reset; the S-box table is a constant and needs none.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_out_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
      row_out_q <= row_d;
    end
  end

endmodule

// File: tb/tb_aes_s_box.sv
// Self-checking bench for aes_s_box: S-box reference derived from GF(2^8)
// inversion and the affine map, plus literal anchor values.
module tb_aes_s_box;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] row_in = 32'h0;
  logic [31:0] row_out;
  logic [31:0] row_out_q;

  int checks = 0;
  int errors = 0;

  logic [7:0]  model [256];
  logic [31:0] exp_q = 32'h0;
  logic        cmp_en = 1'b0;

  aes_s_box dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .row_out   (row_out),
    .row_out_q (row_out_q)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in;
    logic [7:0] b = b_in;
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] w);
    return {model[w[31:24]], model[w[23:16]], model[w[15:8]], model[w[7:0]]};
  endfunction

  // Reference table: multiplicative inverse (0 -> 0) followed by the affine map.
  task automatic build_model();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      model[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  // Expected register content: cleared by reset, otherwise last edge's S-box of the input.
  always @(posedge clk or posedge rst) begin
    if (rst) exp_q = 32'h0;
    else     exp_q = model_word(row_in);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmb_row_out", row_out, model_word(row_in));
      check("reg_row_out_q", row_out_q, exp_q);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    build_model();

    check("model_00", {24'h0, model[8'h00]}, 32'h63);
    check("model_11", {24'h0, model[8'h11]}, 32'h82);
    check("model_fc", {24'h0, model[8'hfc]}, 32'hb0);
    check("model_ff", {24'h0, model[8'hff]}, 32'h16);
    check("model_53", {24'h0, model[8'h53]}, 32'hed);
    check("model_80", {24'h0, model[8'h80]}, 32'hcd);

    #1;
    check("reset_q", row_out_q, 32'h0);
    check("reset_row_out_valid", row_out, 32'h63636363);
    #4 rst = 1'b0;
    cmp_en = 1'b1;

    next_cycle();
    row_in = 32'h00112233;
    #10 check("anchor_a_cmb", row_out, 32'h638293c3);
    next_cycle();
    check("anchor_a_reg", row_out_q, 32'h638293c3);

    row_in = 32'hfcfdfeff;
    #1 check("anchor_b_cmb", row_out, 32'hb054bb16);
    check("anchor_b_reg_holds", row_out_q, 32'h638293c3);
    next_cycle();
    check("anchor_b_reg", row_out_q, 32'hb054bb16);

    // Asynchronous reset between edges.
    #3 rst = 1'b1;
    #1 check("async_rst_q", row_out_q, 32'h0);
    check("async_rst_cmb", row_out, 32'hb054bb16);
    row_in = 32'h00112233;
    #1 check("rst_cmb_tracks", row_out, 32'h638293c3);
    next_cycle();
    check("rst_holds_q", row_out_q, 32'h0);
    row_in = 32'h01108053;
    #1 check("anchor_c_cmb", row_out, 32'h7ccacded);
    #2 rst = 1'b0;
    next_cycle();
    check("anchor_c_reg", row_out_q, 32'h7ccacded);

    for (int x = 0; x < 256; x++) begin
      row_in = {4{8'(x)}};
      #1;
      for (int l = 0; l < 4; l++)
        check($sformatf("sweep_x%02h_l%0d", x, l), {24'h0, row_out[8*l +: 8]}, {24'h0, model[x]});
      next_cycle();
    end

    for (int l = 0; l < 4; l++) begin
      for (int x = 0; x < 256; x += 7) begin
        logic [31:0] w;
        logic [31:0] e;
        w = 32'(x) << (8 * l);
        e = 32'h63636363;
        e[8*l +: 8] = model[x];
        row_in = w;
        #1 check($sformatf("walk_l%0d_x%02h", l, x), row_out, e);
        next_cycle();
      end
    end

    // Back-to-back random words: register must show each previous word exactly once.
    begin
      logic [31:0] prev;
      prev = row_in;
      for (int n = 0; n < 16; n++) begin
        row_in = $urandom;
        #1 check($sformatf("rand_q_%0d", n), row_out_q, model_word(prev));
        prev = row_in;
        next_cycle();
      end
      check("rand_q_last", row_out_q, model_word(prev));
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
